// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size/state encodings and counter width for dmem_wait_ctrl
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for WAIT_STATES in 0..15
    localparam int WS_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane enables, store replication, load extraction/extension, misalign flag
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [31:0] shifted;
    logic [15:0] half;

    assign shifted = rword >> {addr_lo, 3'b000};
    assign half    = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Reserved size 2'b11 falls into the default (word) arm everywhere
    always_comb begin
        byte_en  = 4'b1111;
        wword    = wdata;
        load_val = rword;
        misalign = (addr_lo != 2'b00);
        case (size)
            SZ_BYTE: begin
                byte_en  = 4'b0001 << addr_lo;
                wword    = {4{wdata[7:0]}};
                load_val = is_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                misalign = 1'b0;
            end
            SZ_HALF: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                load_val = is_unsigned ? {16'd0, half} : {{16{half[15]}}, half};
                misalign = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// rtl/dmem_wait_ctrl.sv - MEM-stage data memory with ready/response handshake and wait states
// Optional: DMEM_BOUNDS_CHECK_EN flags addresses beyond DEPTH*4 as access errors instead of wrapping.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic                  Ready,
    output logic [31:0]           ReadData,
    output logic                  RespValid,
    output logic                  AlignErr
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t                state, state_next;
    logic [WS_WIDTH-1:0]   cnt, cnt_next;
    logic                  accept, do_access;

    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [1:0]            cap_size;
    logic                  cap_unsigned, cap_write;

    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [1:0]            acc_size;
    logic                  acc_unsigned, acc_write, acc_err;
    logic [IDX_W-1:0]      acc_idx;

    logic [3:0]            byte_en;
    logic [31:0]           wword, load_val;
    logic                  misalign;

    logic [31:0]           mem [DEPTH];

    assign Ready     = (state != S_WAIT);
    assign RespValid = (state == S_RESP);
    assign accept    = Ready && (MemRead || MemWrite);

    // Zero-wait access happens on the accepting edge, so it uses the live request
    assign acc_addr     = (WAIT_STATES == 0) ? Address   : cap_addr;
    assign acc_wdata    = (WAIT_STATES == 0) ? WriteData : cap_wdata;
    assign acc_size     = (WAIT_STATES == 0) ? Size      : cap_size;
    assign acc_unsigned = (WAIT_STATES == 0) ? Unsigned  : cap_unsigned;
    assign acc_write    = (WAIT_STATES == 0) ? MemWrite  : cap_write;
    assign acc_idx      = acc_addr[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign acc_err = misalign || (|acc_addr[ADDR_WIDTH-1:IDX_W+2]);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr[ADDR_WIDTH-1:IDX_W+2];
    assign acc_err = misalign;
`endif

    dmem_lane_align u_lane_align (
        .addr_lo     (acc_addr[1:0]),
        .size        (acc_size),
        .is_unsigned (acc_unsigned),
        .wdata       (acc_wdata),
        .rword       (mem[acc_idx]),
        .byte_en     (byte_en),
        .wword       (wword),
        .load_val    (load_val),
        .misalign    (misalign)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_access  = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                state_next = S_IDLE;
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_RESP;
                        do_access  = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WS_WIDTH'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt - WS_WIDTH'(1);
                if (cnt == WS_WIDTH'(1)) begin
                    state_next = S_RESP;
                    do_access  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ReadData     <= '0;
            AlignErr     <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_size     <= SZ_BYTE;
            cap_unsigned <= 1'b0;
            cap_write    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_addr     <= Address;
                cap_wdata    <= WriteData;
                cap_size     <= Size;
                cap_unsigned <= Unsigned;
                cap_write    <= MemWrite;
            end
            if (do_access) begin
                ReadData <= (acc_write || acc_err) ? 32'd0 : load_val;
                AlignErr <= acc_err;
            end
        end
    end

    // Array is not reset; Reset gating drops a store that coincides with reset
    always_ff @(posedge Clk) begin
        if (Reset && do_access && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb/tb_dmem_wait_ctrl.sv - directed scoreboard bench for dmem_wait_ctrl at 0 and 3 wait states
module tb_dmem_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address   [2];
    logic [31:0] write_data[2];
    logic        mem_write [2];
    logic        mem_read  [2];
    logic [1:0]  size      [2];
    logic        uns       [2];
    logic        ready     [2];
    logic [31:0] read_data [2];
    logic        resp_valid[2];
    logic        align_err [2];

    int checks = 0;
    int errors = 0;
    logic [32:0] sbq[$];
    int ws_of[2] = '{0, 3};

    always #5 clk = ~clk;

    dmem_wait_ctrl #(.DEPTH(1024), .ADDR_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(rst_n), .Address(address[0]), .WriteData(write_data[0]),
        .MemWrite(mem_write[0]), .MemRead(mem_read[0]), .Size(size[0]), .Unsigned(uns[0]),
        .Ready(ready[0]), .ReadData(read_data[0]), .RespValid(resp_valid[0]), .AlignErr(align_err[0])
    );

    dmem_wait_ctrl #(.DEPTH(1024), .ADDR_WIDTH(32), .WAIT_STATES(3)) dut1 (
        .Clk(clk), .Reset(rst_n), .Address(address[1]), .WriteData(write_data[1]),
        .MemWrite(mem_write[1]), .MemRead(mem_read[1]), .Size(size[1]), .Unsigned(uns[1]),
        .Ready(ready[1]), .ReadData(read_data[1]), .RespValid(resp_valid[1]), .AlignErr(align_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit u);
        address[d] = a; write_data[d] = wd; size[d] = sz; uns[d] = u;
        mem_write[d] = wr; mem_read[d] = !wr;
    endtask

    task automatic accept_edge(input int d, input string tag);
        int n = 0;
        logic rdy;
        do begin
            rdy = ready[d];
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        check({tag, "_accept"}, 32'(rdy), 32'd1);
    endtask

    task automatic wait_resp(input int d, input string tag);
        int n = 0;
        logic [32:0] e;
        while (1) begin
            @(negedge clk);
            if (resp_valid[d]) break;
            check({tag, "_ready_wait"}, 32'(ready[d]), 32'd0);
            n++;
            if (n > 20) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(ws_of[d]));
        check({tag, "_ready_resp"}, 32'(ready[d]), 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, "_rdata"}, read_data[d], e[31:0]);
            check({tag, "_err"}, 32'(align_err[d]), 32'(e[32]));
        end else begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end
    endtask

    task automatic req(input int d, input string tag, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input bit u,
                       input logic [31:0] exp_rd, input bit exp_err);
        @(negedge clk);
        drive(d, wr, a, wd, sz, u);
        sbq.push_back({exp_err, exp_rd});
        accept_edge(d, tag);
        #1 mem_write[d] = 1'b0; mem_read[d] = 1'b0;
        wait_resp(d, tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
        mem_read[0] = 1'b0; mem_read[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready[d]), 32'd1);
            check("rst_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_rdata", read_data[d], 32'd0);
            check("rst_err", 32'(align_err[d]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // zero wait states
        req(0, "sw10",   1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0,        0);
        req(0, "lw10",   0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
        req(0, "lb13",   0, 32'h13,   32'h0,        2'b00, 0, 32'hFFFFFFDE, 0);
        req(0, "lbu13",  0, 32'h13,   32'h0,        2'b00, 1, 32'h000000DE, 0);
        req(0, "lh10",   0, 32'h10,   32'h0,        2'b01, 0, 32'hFFFFBEEF, 0);
        req(0, "lhu12",  0, 32'h12,   32'h0,        2'b01, 1, 32'h0000DEAD, 0);
        req(0, "sb11",   1, 32'h11,   32'h55,       2'b00, 0, 32'h0,        0);
        req(0, "lw10b",  0, 32'h10,   32'h0,        2'b10, 1, 32'hDEAD55EF, 0);
        req(0, "lh11",   0, 32'h11,   32'h0,        2'b01, 0, 32'h0,        1);
        req(0, "sw12",   1, 32'h12,   32'h11111111, 2'b10, 0, 32'h0,        1);
        req(0, "lw10c",  0, 32'h10,   32'h0,        2'b10, 0, 32'hDEAD55EF, 0);
        req(0, "lwrap",  0, 32'h1010, 32'h0,        2'b10, 0, 32'hDEAD55EF, 0);
        req(0, "lsz3",   0, 32'h10,   32'h0,        2'b11, 0, 32'hDEAD55EF, 0);

        // three wait states
        req(1, "sw20",   1, 32'h20,   32'hCAFEF00D, 2'b10, 0, 32'h0,        0);

        // back-to-back: second request held through WAIT, accepted in RESP
        @(negedge clk);
        drive(1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        sbq.push_back({1'b0, 32'hCAFEF00D});
        accept_edge(1, "b2b_a");
        #1 drive(1, 1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
        sbq.push_back({1'b0, 32'h000000F0});
        wait_resp(1, "b2b_a");
        @(posedge clk);
        #1 mem_read[1] = 1'b0;
        wait_resp(1, "b2b_b");

        // reset during WAIT drops the store
        @(negedge clk);
        drive(1, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        accept_edge(1, "rstw");
        #1 mem_write[1] = 1'b0;
        @(negedge clk);
        check("rstw_in_wait", 32'(ready[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstw_ready", 32'(ready[1]), 32'd1);
        check("rstw_valid", 32'(resp_valid[1]), 32'd0);
        check("rstw_rdata", read_data[1], 32'd0);
        check("rstw_err", 32'(align_err[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstw_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        req(1, "lw20",   0, 32'h20,   32'h0,        2'b10, 0, 32'hCAFEF00D, 0);
        req(1, "lh21w",  0, 32'h21,   32'h0,        2'b01, 0, 32'h0,        1);
        req(0, "lw10r",  0, 32'h10,   32'h0,        2'b10, 0, 32'hDEAD55EF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
